// File: rtl/sdram_pkg.sv
// sdram_pkg -- shared definitions for the SDRAM controller slice.
//   Command encodings are {cs_n, ras_n, cas_n, we_n}.
//   Arbiter state encoding uses plain localparam constants.
//   Widths: ADDR_W (row/column address), BA_W (bank), DQ_W (data bus), CMD_W.
//   grant_t is the arbiter's one-per-cycle pick.
package sdram_pkg;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;
  localparam int CMD_W  = 4;

  localparam logic [CMD_W-1:0] CMD_MRS       = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_AREF      = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WRITE     = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_READ      = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;

  // Idle bus values driven while arbitrating.
  localparam logic [BA_W-1:0]   IDLE_BA   = 2'b11;
  localparam logic [ADDR_W-1:0] IDLE_ADDR = 13'h1FFF;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_ARBIT = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REF  = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } grant_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// sdram_arb_prio -- picks which pending client gets the SDRAM next.
//   Refresh always wins. Between write and read:
//     default build          : write always beats read.
//     SDRAM_ARB_RR_EN defined: the one not granted most recently wins
//                              (last-grant flag resets to "read", so the
//                              first tie goes to write).
// Ports:
//   i_sysclk, i_sysrst_n : clock / async active-low reset (SDRAM_ARB_RR_EN only)
//   i_arb_en             : arbiter is in ARBIT; a non-NONE pick is a real grant
//   i_refresh_req, i_wr_req, i_rd_req : pending requests
//   o_pick               : selected client (GNT_NONE when nothing pending)
module sdram_arb_prio
  import sdram_pkg::*;
(
`ifdef SDRAM_ARB_RR_EN
  input  logic   i_sysclk,
  input  logic   i_sysrst_n,
  input  logic   i_arb_en,
`endif
  input  logic   i_refresh_req,
  input  logic   i_wr_req,
  input  logic   i_rd_req,
  output grant_t o_pick
);

`ifdef SDRAM_ARB_RR_EN
  // 1 = write was granted last, 0 = read was granted last.
  logic last_wr;

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      last_wr <= 1'b0;
    end else if (i_arb_en) begin
      if (o_pick == GNT_WR) last_wr <= 1'b1;
      else if (o_pick == GNT_RD) last_wr <= 1'b0;
    end
  end
`endif

  always_comb begin
    o_pick = GNT_NONE;
    if (i_refresh_req) begin
      o_pick = GNT_REF;
    end else if (i_wr_req && i_rd_req) begin
`ifdef SDRAM_ARB_RR_EN
      o_pick = last_wr ? GNT_RD : GNT_WR;
`else
      o_pick = GNT_WR;
`endif
    end else if (i_wr_req) begin
      o_pick = GNT_WR;
    end else if (i_rd_req) begin
      o_pick = GNT_RD;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter -- shares the SDRAM command/data bus between the init,
// refresh, write and read engines.
//   INIT  : init engine drives the bus until i_init_done is sampled high.
//   ARBIT : bus idles at NOP/ba 3/addr 1FFF; one request granted per edge,
//           refresh > write > read (round-robin write/read when
//           SDRAM_ARB_RR_EN is defined, see sdram_arb_prio).
//   AREF/WRITE/READ : granted client owns the bus until its done pulse;
//           no preemption. Every grant returns through ARBIT, so at least
//           one NOP cycle separates consecutive grants.
// Ports:
//   i_sysclk, i_sysrst_n        : 100 MHz clock, async active-low reset
//   i_init_*                    : init engine command/bank/address, done
//   i_refresh_*, o_refresh_start: refresh engine handshake and bus
//   i_wr_*, o_wr_start          : write engine handshake, bus and data
//   i_rd_*, o_rd_start          : read engine handshake and bus
//   o_sdram_*                   : SDRAM pins; DQ tristated at top via dq_oe
// Configuration macro: SDRAM_ARB_RR_EN (write/read round-robin).
module sdram_arbiter
  import sdram_pkg::*;
(
  input  logic              i_sysclk,
  input  logic              i_sysrst_n,
  input  logic              i_init_done,
  input  logic [CMD_W-1:0]  i_init_cmd,
  input  logic [BA_W-1:0]   i_init_ba,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic              i_refresh_request,
  input  logic [CMD_W-1:0]  i_refresh_cmd,
  input  logic [BA_W-1:0]   i_refresh_ba,
  input  logic [ADDR_W-1:0] i_refresh_addr,
  input  logic              i_refresh_done,
  output logic              o_refresh_start,
  input  logic              i_wr_request,
  input  logic [CMD_W-1:0]  i_wr_cmd,
  input  logic [BA_W-1:0]   i_wr_ba,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_done,
  input  logic              i_wr_sdram_en,
  input  logic [DQ_W-1:0]   i_wr_data,
  output logic              o_wr_start,
  input  logic              i_rd_request,
  input  logic [CMD_W-1:0]  i_rd_cmd,
  input  logic [BA_W-1:0]   i_rd_ba,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_done,
  output logic              o_rd_start,
  output logic              o_sdram_cs_n,
  output logic              o_sdram_ras_n,
  output logic              o_sdram_cas_n,
  output logic              o_sdram_we_n,
  output logic [BA_W-1:0]   o_sdram_ba,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic [DQ_W-1:0]   o_sdram_dq,
  output logic              o_sdram_dq_oe
);

  logic [2:0]        state;
  grant_t            pick;
  logic [CMD_W-1:0]  cmd;

  sdram_arb_prio u_prio (
`ifdef SDRAM_ARB_RR_EN
    .i_sysclk      (i_sysclk),
    .i_sysrst_n    (i_sysrst_n),
    .i_arb_en      (state == ST_ARBIT),
`endif
    .i_refresh_req (i_refresh_request),
    .i_wr_req      (i_wr_request),
    .i_rd_req      (i_rd_request),
    .o_pick        (pick)
  );

  // State and start flags change together, so start is high exactly while
  // the matching grant state is held; this keeps the starts mutually
  // exclusive by construction.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state           <= ST_INIT;
      o_refresh_start <= 1'b0;
      o_wr_start      <= 1'b0;
      o_rd_start      <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (i_init_done) state <= ST_ARBIT;
        end
        ST_ARBIT: begin
          case (pick)
            GNT_REF: begin
              state           <= ST_AREF;
              o_refresh_start <= 1'b1;
            end
            GNT_WR: begin
              state      <= ST_WRITE;
              o_wr_start <= 1'b1;
            end
            GNT_RD: begin
              state      <= ST_READ;
              o_rd_start <= 1'b1;
            end
            default: ;
          endcase
        end
        // Only the granted client's done is looked at; others are ignored.
        ST_AREF: begin
          if (i_refresh_done) begin
            state           <= ST_ARBIT;
            o_refresh_start <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (i_wr_done) begin
            state      <= ST_ARBIT;
            o_wr_start <= 1'b0;
          end
        end
        ST_READ: begin
          if (i_rd_done) begin
            state      <= ST_ARBIT;
            o_rd_start <= 1'b0;
          end
        end
        default: begin
          state           <= ST_INIT;
          o_refresh_start <= 1'b0;
          o_wr_start      <= 1'b0;
          o_rd_start      <= 1'b0;
        end
      endcase
    end
  end

  // Bus mux: owner's command goes straight to the pins with no register,
  // so the engines keep exact control of command timing.
  always_comb begin
    cmd          = i_init_cmd;
    o_sdram_ba   = i_init_ba;
    o_sdram_addr = i_init_addr;
    case (state)
      ST_ARBIT: begin
        cmd          = CMD_NOP;
        o_sdram_ba   = IDLE_BA;
        o_sdram_addr = IDLE_ADDR;
      end
      ST_AREF: begin
        cmd          = i_refresh_cmd;
        o_sdram_ba   = i_refresh_ba;
        o_sdram_addr = i_refresh_addr;
      end
      ST_WRITE: begin
        cmd          = i_wr_cmd;
        o_sdram_ba   = i_wr_ba;
        o_sdram_addr = i_wr_addr;
      end
      ST_READ: begin
        cmd          = i_rd_cmd;
        o_sdram_ba   = i_rd_ba;
        o_sdram_addr = i_rd_addr;
      end
      default: ;
    endcase
  end

  assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = cmd;

  assign o_sdram_dq_oe = (state == ST_WRITE) && i_wr_sdram_en;
  assign o_sdram_dq    = o_sdram_dq_oe ? i_wr_data : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter -- directed bench for sdram_arbiter with hand-computed
// expected values. Inputs change 1 ns after the rising edge; outputs are
// sampled there too, well away from the next active edge.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;
  logic        ref_req, ref_done;
  logic [3:0]  ref_cmd;
  logic [1:0]  ref_ba;
  logic [12:0] ref_addr;
  logic        ref_start;
  logic        wr_req, wr_done, wr_en;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_start;
  logic        rd_req, rd_done;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;
  logic        rd_start;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [15:0] sd_dq;
  logic        sd_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_arbiter dut (
    .i_sysclk          (clk),
    .i_sysrst_n        (rst_n),
    .i_init_done       (init_done),
    .i_init_cmd        (init_cmd),
    .i_init_ba         (init_ba),
    .i_init_addr       (init_addr),
    .i_refresh_request (ref_req),
    .i_refresh_cmd     (ref_cmd),
    .i_refresh_ba      (ref_ba),
    .i_refresh_addr    (ref_addr),
    .i_refresh_done    (ref_done),
    .o_refresh_start   (ref_start),
    .i_wr_request      (wr_req),
    .i_wr_cmd          (wr_cmd),
    .i_wr_ba           (wr_ba),
    .i_wr_addr         (wr_addr),
    .i_wr_done         (wr_done),
    .i_wr_sdram_en     (wr_en),
    .i_wr_data         (wr_data),
    .o_wr_start        (wr_start),
    .i_rd_request      (rd_req),
    .i_rd_cmd          (rd_cmd),
    .i_rd_ba           (rd_ba),
    .i_rd_addr         (rd_addr),
    .i_rd_done         (rd_done),
    .o_rd_start        (rd_start),
    .o_sdram_cs_n      (cs_n),
    .o_sdram_ras_n     (ras_n),
    .o_sdram_cas_n     (cas_n),
    .o_sdram_we_n      (we_n),
    .o_sdram_ba        (sd_ba),
    .o_sdram_addr      (sd_addr),
    .o_sdram_dq        (sd_dq),
    .o_sdram_dq_oe     (sd_oe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of the command/bank/address pins: {cmd, ba, addr}.
  function automatic logic [31:0] bus();
    return {13'd0, cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr};
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    return {13'd0, c, b, a};
  endfunction

  function automatic logic [31:0] starts();
    return {29'd0, ref_start, wr_start, rd_start};
  endfunction

  localparam logic [31:0] NOP_BUS = {13'd0, 4'b0111, 2'b11, 13'h1FFF};

  // Waits (bounded) for any start, records which one, then pulses the
  // matching done for one cycle.
  task automatic take_grant(output logic [2:0] who);
    int n;
    n = 0;
    while (starts() == 0 && n < 8) begin
      tick();
      n++;
    end
    who = starts();
    if (who == 3'b100) ref_done = 1'b1;
    if (who == 3'b010) wr_done  = 1'b1;
    if (who == 3'b001) rd_done  = 1'b1;
    tick();
    ref_done = 1'b0;
    wr_done  = 1'b0;
    rd_done  = 1'b0;
  endtask

  logic [2:0] g0, g1, g2;

  initial begin
    rst_n = 1'b0; init_done = 1'b0;
    init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
    ref_req = 0; ref_done = 0; ref_cmd = 4'b0001; ref_ba = 2'b00; ref_addr = 13'h0000;
    wr_req = 0; wr_done = 0; wr_en = 0; wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h0123;
    wr_data = 16'hA5A5;
    rd_req = 0; rd_done = 0; rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 13'h0456;
    #1;
    // Reset: init pass-through, no starts, DQ not driven.
    check("rst_bus", bus(), mk(4'b0010, 2'b01, 13'h0400));
    check("rst_starts", starts(), 0);
    check("rst_oe", {31'd0, sd_oe}, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Stay in INIT while init_done low, even with requests pending.
    ref_req = 1'b1;
    repeat (17) tick();
    init_cmd = 4'b0000; init_ba = 2'b00; init_addr = 13'h0033;
    #1;
    check("init_hold_bus", bus(), mk(4'b0000, 2'b00, 13'h0033));
    check("init_hold_starts", starts(), 0);
    ref_req = 1'b0;

    // init_done raised; ARBIT/NOP after the edge that samples it.
    init_done = 1'b1;
    check("init_pre_edge", bus(), mk(4'b0000, 2'b00, 13'h0033));
    tick();
    init_done = 1'b0;
    check("arbit_nop", bus(), NOP_BUS);
    tick();
    check("arbit_nop2", bus(), NOP_BUS);

    // Refresh grant.
    ref_req = 1'b1;
    #1;
    check("ref_pre_grant", starts(), 0);
    tick();
    ref_req = 1'b0;
    check("ref_start", starts(), 3'b100);
    check("ref_bus", bus(), mk(4'b0001, 2'b00, 13'h0000));
    // Done from a client that is not granted is ignored; requests wait.
    wr_done = 1'b1; rd_req = 1'b1;
    tick();
    wr_done = 1'b0;
    check("ref_ignore_wr_done", starts(), 3'b100);
    check("ref_no_preempt", bus(), mk(4'b0001, 2'b00, 13'h0000));
    rd_req = 1'b0;
    ref_done = 1'b1;
    tick();
    ref_done = 1'b0;
    check("ref_done_starts", starts(), 0);
    check("ref_done_nop", bus(), NOP_BUS);

    // All three requests in the same cycle: AREF, WRITE, READ with NOPs between.
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_en = 1'b1;
    tick();
    check("all_g1", starts(), 3'b100);
    check("all_oe_aref", {31'd0, sd_oe}, 0);
    check("all_dq_aref", {16'd0, sd_dq}, 0);
    ref_req = 1'b0; ref_done = 1'b1;
    tick();
    ref_done = 1'b0;
    check("all_gap1_starts", starts(), 0);
    check("all_gap1_nop", bus(), NOP_BUS);
    tick();
    check("all_g2", starts(), 3'b010);
    check("wr_bus", bus(), mk(4'b0100, 2'b10, 13'h0123));
    check("wr_oe", {31'd0, sd_oe}, 1);
    check("wr_dq", {16'd0, sd_dq}, 32'h0000A5A5);
    wr_en = 1'b0;
    #1;
    check("wr_oe_off", {31'd0, sd_oe}, 0);
    check("wr_dq_off", {16'd0, sd_dq}, 0);
    wr_en = 1'b1;
    wr_req = 1'b0; wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("all_gap2_starts", starts(), 0);
    check("all_gap2_nop", bus(), NOP_BUS);
    check("all_gap2_oe", {31'd0, sd_oe}, 0);
    tick();
    check("all_g3", starts(), 3'b001);
    check("rd_bus", bus(), mk(4'b0101, 2'b01, 13'h0456));
    check("rd_oe", {31'd0, sd_oe}, 0);
    rd_req = 1'b0; rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("rd_done_starts", starts(), 0);
    tick();
    check("idle_starts", starts(), 0);

    // Write and read held continuously. Last grant was read.
    wr_req = 1'b1; rd_req = 1'b1;
    take_grant(g0);
    take_grant(g1);
    take_grant(g2);
    check("tie_g0", {29'd0, g0}, 3'b010);
`ifdef SDRAM_ARB_RR_EN
    check("tie_g1", {29'd0, g1}, 3'b001);
`else
    check("tie_g1", {29'd0, g1}, 3'b010);
`endif
    check("tie_g2", {29'd0, g2}, 3'b010);
    rd_req = 1'b0;

    // Reset during WRITE.
    wait_wr: begin
      for (int i = 0; i < 8; i++) begin
        if (wr_start) disable wait_wr;
        tick();
      end
    end
    check("pre_rst_wr", starts(), 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_starts", starts(), 0);
    check("mid_rst_bus", bus(), mk(4'b0000, 2'b00, 13'h0033));
    check("mid_rst_oe", {31'd0, sd_oe}, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_starts", starts(), 0);
    check("post_rst_bus", bus(), mk(4'b0000, 2'b00, 13'h0033));
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    check("reinit_nop", bus(), NOP_BUS);
    check("reinit_starts", starts(), 0);
    tick();
    check("reinit_wr", starts(), 3'b010);
    wr_req = 1'b0; wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("final_starts", starts(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Mutual exclusion of starts, checked every cycle.
  always @(negedge clk) begin
    if ((ref_start + wr_start + rd_start) > 1) begin
      bad++;
      $display("FAIL start_onehot: got %b, expected at most one", {ref_start, wr_start, rd_start});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first: i_sysclk in 1 (clock, 100 MHz domain); i_sysrst_n in 1 (reset, asynchronous, active-low).
REQ-002 SHALL have init inputs: i_init_done in 1; i_init_cmd in 4; i_init_ba in 2; i_init_addr in 13.
REQ-003 SHALL have refresh ports: i_refresh_request in 1; i_refresh_cmd in 4; i_refresh_ba in 2; i_refresh_addr in 13; i_refresh_done in 1; o_refresh_start out 1.
REQ-004 SHALL have write ports: i_wr_request in 1; i_wr_cmd in 4; i_wr_ba in 2; i_wr_addr in 13; i_wr_done in 1; i_wr_sdram_en in 1 (drive DQ); i_wr_data in 16; o_wr_start out 1.
REQ-005 SHALL have read ports: i_rd_request in 1; i_rd_cmd in 4; i_rd_ba in 2; i_rd_addr in 13; i_rd_done in 1; o_rd_start out 1.
REQ-006 SHALL have SDRAM-side outputs: o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n out 1 each (cmd[3:0] in that order); o_sdram_ba out 2; o_sdram_addr out 13; o_sdram_dq out 16; o_sdram_dq_oe out 1 (top level tristates DQ).

Function
REQ-007 SHALL implement FSM states INIT, ARBIT, AREF, WRITE, READ.
REQ-008 INIT: SHALL pass i_init_cmd/ba/addr to SDRAM outputs; SHALL move to ARBIT on the edge after i_init_done is sampled high.
REQ-009 ARBIT: SHALL drive cmd NOP 4'b0111, ba 2'b11, addr 13'h1FFF; SHALL grant one pending request per edge, priority refresh > write > read.
REQ-010 Grant: request sampled high at edge N SHALL make state AREF/WRITE/READ and the matching o_*_start high from edge N+1 (registered).
REQ-011 o_*_start SHALL stay high until the matching i_*_done is sampled high, then clear on that edge; state returns to ARBIT on the same edge.
REQ-012 AREF/WRITE/READ SHALL mux that client's cmd/ba/addr combinationally to SDRAM outputs; other clients ignored.
REQ-013 A request arriving while another client is granted SHALL wait; no preemption, including refresh.
REQ-014 Done and a new request in the same cycle: SHALL spend at least one ARBIT (NOP) cycle before the next grant.
REQ-015 Done from a non-granted client SHALL be ignored.
REQ-016 o_sdram_dq_oe SHALL equal (state==WRITE) & i_wr_sdram_en; o_sdram_dq SHALL equal i_wr_data when oe, else 16'h0000.
REQ-017 At most one o_*_start SHALL be high in any cycle.
REQ-018 If i_init_done is never asserted, FSM SHALL stay in INIT indefinitely.

Reset
REQ-019 On i_sysrst_n low, asynchronously: state INIT; o_refresh_start, o_wr_start, o_rd_start 0; dq_oe 0; SDRAM outputs follow init inputs.
REQ-020 Reset mid-operation SHALL abandon any grant; no start asserted until init completes again.

Configuration
REQ-021 With SDRAM_ARB_RR_EN defined: when write and read are both pending in ARBIT, SHALL grant the one not granted most recently (1-bit last-grant flag, reset to "read", so write wins first tie); refresh still highest.
REQ-022 Without SDRAM_ARB_RR_EN: write SHALL always beat read; no last-grant flag present.

Structure
REQ-023 SHALL use shared package sdram_pkg for: command codes (NOP 4'b0111, PRECHARGE, AREF, ACTIVE, WRITE, READ, MRS), state encoding, widths (ADDR_W 13, BA_W 2, DQ_W 16).
REQ-024 Priority/round-robin selection SHALL be a sub-module sdram_arb_prio (combinational pick plus last-grant register when SDRAM_ARB_RR_EN); mux and FSM remain in sdram_arbiter.

Verification
REQ-025 Reset, init_done high at cycle 20 -> INIT to ARBIT at cycle 21; outputs NOP/ba 3/addr 1FFF thereafter.
REQ-026 Refresh request in ARBIT -> o_refresh_start high next cycle; refresh_cmd 4'b0001 appears on cs/ras/cas/we; done pulse -> start low, ARBIT, NOP next cycle.
REQ-027 Refresh, write, read requests raised same cycle -> grant order AREF, WRITE, READ, each separated by >=1 NOP cycle.
REQ-028 Write grant with i_wr_sdram_en high, i_wr_data 16'hA5A5 -> o_sdram_dq 16'hA5A5, oe 1; oe 0 in all other states.
REQ-029 SDRAM_ARB_RR_EN defined, write and read held continuously -> grants alternate WRITE, READ, WRITE; undefined -> WRITE only.
REQ-030 Reset asserted during WRITE -> start signals 0 immediately, state INIT, no grant until init_done re-asserted.
